// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned approximate multiplier. Rows of partial products are paired
// into a half-adder array whose low columns can be OR-summed or eliminated.
module approx_mul_pipe #(
  parameter int W  = 8,
  parameter int TW = $clog2(2*W)+1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic [1:0]    mode,
  input  logic [TW-1:0] thr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*W-1:0] p,
  output logic [1:0]    p_mode
);

  localparam int PW = 2*W;
  localparam int NP = W/2;

  logic          vld_p1, vld_p2, vld_p3;
  logic          ld1, ld2, ld3;
  logic [1:0]    md_p0, md_p1, md_p2;
  logic          is_or_p0, is_el_p0, is_apx_p0;
  logic [PW-2:0] lt_p0;
  logic [PW-1:0] ps_p0 [NP];
  logic [PW-1:0] pc_p0 [NP];
  logic [PW-1:0] ps_p1 [NP];
  logic [PW-1:0] pc_p1 [NP];
  logic [PW-1:0] red_s, red_c;
  logic [PW-1:0] s_p2, c_p2;

  // 3:2 compressor over whole vectors: returns {sum, carry shifted to its weight}.
  function automatic logic [2*PW-1:0] csa32(input logic [PW-1:0] a,
                                            input logic [PW-1:0] b,
                                            input logic [PW-1:0] c);
    logic [PW-1:0] s, cy;
    s  = a ^ b ^ c;
    cy = ((a & b) | (a & c) | (b & c)) << 1;
    return {s, cy};
  endfunction

  // Handshake: a stage loads when empty or when its successor advances.
  assign ld3       = vld_p2 & (~vld_p3 | out_ready);
  assign ld2       = vld_p1 & (~vld_p2 | ld3);
  assign in_ready  = ~vld_p1 | ld2;
  assign ld1       = in_valid & in_ready & ~rst;
  assign out_valid = vld_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p1 <= ld1 | (vld_p1 & ~ld2);
      vld_p2 <= ld2 | (vld_p2 & ~ld3);
      vld_p3 <= ld3 | (vld_p3 & ~out_ready);
    end
  end

  // ---- stage 0: paired half-adder array with per-column approximation
  assign md_p0     = (mode == 2'd3) ? 2'd0 : mode;
  assign is_or_p0  = (md_p0 == 2'd1);
  assign is_el_p0  = (md_p0 == 2'd2);
  assign is_apx_p0 = (md_p0 != 2'd0);

  for (genvar c = 0; c < PW-1; c++) begin : g_thr
    assign lt_p0[c] = (thr > TW'(c));
  end

  for (genvar k = 0; k < NP; k++) begin : g_pair
    localparam int B = 2*k;
    logic [W-2:0] ov_s, ov_c;
    logic         na, nb;
    for (genvar j = 1; j < W; j++) begin : g_col
      logic a, b, apx;
      assign a   = x[B] & y[j];
      assign b   = x[B+1] & y[j-1];
      assign apx = lt_p0[B+j];
      assign ov_s[j-1] = (apx & is_el_p0) ? 1'b0 :
                         (apx & is_or_p0) ? (a | b) : (a ^ b);
      assign ov_c[j-1] = (apx & is_apx_p0) ? 1'b0 : (a & b);
    end
    // Non-overlap bits only drop out in eliminate mode.
    assign na = x[B] & y[0] & ~(is_el_p0 & lt_p0[B]);
    assign nb = x[B+1] & y[W-1] & ~(is_el_p0 & lt_p0[B+W]);
    assign ps_p0[k] = {{(W-1){1'b0}}, nb, ov_s, na} << B;
    assign pc_p0[k] = {{(W-1){1'b0}}, ov_c, 2'b00} << B;
  end

  // ---- stage 1: register pair sum/carry vectors
  always_ff @(posedge clk) begin
    if (ld1) begin
      ps_p1 <= ps_p0;
      pc_p1 <= pc_p0;
      md_p1 <= md_p0;
    end
  end

  always_comb begin
    logic [2*PW-1:0] t;
    red_s = ps_p1[0];
    red_c = pc_p1[0];
    t     = '0;
    for (int k = 1; k < NP; k++) begin
      t     = csa32(red_s, red_c, ps_p1[k]);
      red_s = t[2*PW-1:PW];
      red_c = t[PW-1:0];
      t     = csa32(red_s, red_c, pc_p1[k]);
      red_s = t[2*PW-1:PW];
      red_c = t[PW-1:0];
    end
  end

  // ---- stage 2: register the carry-save pair
  always_ff @(posedge clk) begin
    if (ld2) begin
      s_p2  <= red_s;
      c_p2  <= red_c;
      md_p2 <= md_p1;
    end
  end

  // ---- stage 3: carry-propagate add into the product register
  always_ff @(posedge clk) begin
    if (rst) begin
      p      <= '0;
      p_mode <= 2'd0;
    end else if (ld3) begin
      p      <= s_p2 + c_p2;
      p_mode <= md_p2;
    end
  end

endmodule

// File: doc/approx_mul_pipe.md
# approx_mul_pipe

Parametrised, pipelined unsigned approximate multiplier, successor to the fixed 8x8 half-adder-array partial-product generators. Partial products are paired row by row into a half-adder array. Columns below a run-time threshold are approximated with one of three modes: exact HA, OR-sum or eliminate. The paired rows are then reduced and summed to a full product behind a valid/ready handshake. It sits between operand FIFOs and the accumulator datapath, and allows per-transaction accuracy/energy trade-off.

## Interface
- W, default 8: operand width; even, 4..16.
- TW, default $clog2(2*W)+1: width of threshold field.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands this cycle.
- x  in  W  multiplicand, unsigned.
- y  in  W  multiplier, unsigned.
- mode  in  2  approximation mode: 0 exact, 1 OR-sum, 2 eliminate, 3 reserved (treated as 0).
- thr  in  TW  column threshold; columns of weight < thr are approximated; values > 2W behave as 2W.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- p  out  2W  product.
- p_mode  out  2  mode tag travelling with p (reserved 3 reported as 0).

## Operation
- Partial product pp(i,j) = x[i] & y[j], weight i+j.
- Row pair k (k = 0..W/2-1) has row A = x[2k]&y at offset 2k and row B = x[2k+1]&y at offset 2k+1.
- Overlap columns c = 2k+1..2k+W-1 use a = pp(2k, c-2k) and b = pp(2k+1, c-2k-1).
- Non-overlap bits are row A weight 2k and row B weight 2k+W. They pass through.
- Per overlap column, when c >= thr or mode 0: half adder, sum = a^b at weight c, carry = a&b at weight c+1.
- Mode 1 with c < thr: sum = a|b, carry = 0.
- Mode 2 with c < thr: sum = carry = 0. Non-overlap bits with weight < thr are also zeroed.
- Pair outputs are a sum vector plus a carry vector, each 2W wide. The product is the modular 2W-bit sum of all W/2 pair outputs. No further approximation is applied after the HA array.
- thr = 0 with any mode gives the exact product.
- Sampled mode/thr apply only to the transaction accepted with them. Changing them between transfers is legal with no bubble.

## Timing
- Three-stage pipeline:
  - S1 registers the pair sum/carry vectors.
  - S2 registers the reduction to two 2W vectors (CSA tree).
  - S3 registers the final carry-propagate sum into p.
- Latency from accept (in_valid & in_ready) to out_valid is 3 cycles when there is no backpressure. Throughput is 1 per cycle.
- Each stage holds a valid bit. A stage loads when it is empty or its downstream stage advances this cycle.
- in_ready = !v1 | (S1 advances). in_ready is combinational from out_ready and must be registered-path safe; there is no combinational path from in_valid to in_ready.
- Backpressure: with out_valid=1 and out_ready=0, p, p_mode and out_valid hold stable. Up to 3 transactions are buffered. in_ready drops only once all three stages are full.
- A simultaneous out-transfer and in-transfer in the full state keeps occupancy at 3 with no bubble.
- Reset: all valid bits clear, and p = 0, p_mode = 0, out_valid = 0 on the cycle after rst. in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight transactions. Data registers need not clear, except p/p_mode.
- in_valid while rst=1 is ignored.

## Test plan
- Exact corners, W=8, mode 0: x=255, y=255 -> p=65025. Then x=0, y=200 -> p=0. Then x=1, y=173 -> p=173. Each appears 3 cycles after accept.
- OR mode, W=8: x=3, y=3, mode 1, thr=2 -> p=7. The same operands with thr=0 -> p=9.
- Eliminate mode, W=8: x=3, y=3, mode 2, thr=2 -> p=4. Then x=255, y=255, mode 2, thr=16 -> p=0, p_mode=2.
- Backpressure: stream 6 back-to-back transactions with out_ready low for 5 cycles. in_ready must fall after 3 accepts, and p must hold stable. On release, all 6 products emerge in order with no loss or duplication.
- Reset mid-flight: accept 2 transactions, assert rst for 1 cycle. No out_valid follows, p=0, and in_ready=1 the next cycle. A new transaction x=10, y=12 -> p=120.
- Random compare against a bit-level reference model implementing the column rules, for W=8 and W=16, across all modes and thr 0..2W, with random out_ready.
